// File: rtl/multivoice_pkg.sv
// Shared types and helpers for the multi-voice tone generator.
package multivoice_pkg;

    localparam int unsigned MAX_DIV_W = 32;

    typedef enum logic [1:0] {
        OCT_NONE = 2'd0,
        OCT_UP   = 2'd1,
        OCT_DOWN = 2'd2
    } oct_mode_t;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < val) r = r + 1;
        return r;
    endfunction

    // Up and down together cancel out.
    function automatic oct_mode_t oct_mode(input logic up, input logic down);
        if (up && !down) return OCT_UP;
        if (down && !up) return OCT_DOWN;
        return OCT_NONE;
    endfunction

    // One extra bit so an octave-down shift never overflows.
    function automatic logic [MAX_DIV_W:0] eff_period(input logic [MAX_DIV_W-1:0] div,
                                                      input oct_mode_t mode);
        logic [MAX_DIV_W:0] d;
        d = {1'b0, div};
        eff_period = d;
        if (div == '0) begin
            eff_period = '0;
        end else begin
            case (mode)
                OCT_UP:   eff_period = ((d >> 1) == '0) ? (MAX_DIV_W+1)'(1) : (d >> 1);
                OCT_DOWN: eff_period = d << 1;
                default:  eff_period = d;
            endcase
        end
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: half-period counter reloaded from the effective divider.
module tone_voice
    import multivoice_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_ena,
    input  oct_mode_t        i_oct_mode,
    output logic             o_square
);

    logic [DIV_W:0] w_eff;
    logic [DIV_W:0] r_cnt;
    logic           r_square;

    assign w_eff = (DIV_W+1)'(eff_period(MAX_DIV_W'(i_div), i_oct_mode));

    // Divider/octave are only looked at on reload, so a half-period always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_square <= 1'b0;
        end else if (!i_ena) begin
            r_cnt    <= '0;
            r_square <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - (DIV_W+1)'(1);
        end else if (w_eff == '0) begin
            r_square <= 1'b0;
        end else begin
            r_square <= ~r_square;
            r_cnt    <= w_eff - (DIV_W+1)'(1);
        end
    end

    assign o_square = r_square;

endmodule

// File: rtl/multivoice_tone_gen.sv
// N-voice square-wave generator with tremolo gating, LED mirror and
// first-order sigma-delta mixing onto a single audio bit.
module multivoice_tone_gen
    import multivoice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 2,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned TREM_DIV_W = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_VOICES*DIV_W-1:0] i_voice_div,
    input  logic [NUM_VOICES-1:0]       i_voice_ena,
    input  logic                        i_octave_uena,
    input  logic                        i_octave_dena,
    input  logic                        i_tremolo_ena,
    input  logic                        i_led_ena,
    output logic                        o_out_full,
    output logic [NUM_VOICES-1:0]       o_led_out
);

    localparam int unsigned ACC_W  = clog2(2 * NUM_VOICES);
    localparam int unsigned SYNC_W = NUM_VOICES + 4;

    logic [SYNC_W-1:0]     w_async;
    logic [SYNC_W-1:0]     r_sync1;
    logic [SYNC_W-1:0]     r_sync2;
    logic [NUM_VOICES-1:0] w_ena;
    logic                  w_oct_up;
    logic                  w_oct_down;
    logic                  w_trem_ena;
    logic                  w_led_ena;
    oct_mode_t             w_oct_mode;
    logic [NUM_VOICES-1:0] w_square;
    logic [NUM_VOICES-1:0] w_gated;
    logic [TREM_DIV_W-1:0] r_lfo;
    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_sum;
    logic [ACC_W-1:0]      w_acc_next;
    logic                  w_over;
    logic                  r_out_full;
    logic [NUM_VOICES-1:0] r_led_out;

    assign w_async = {i_led_ena, i_tremolo_ena, i_octave_dena, i_octave_uena, i_voice_ena};

    // Two-flop synchronisers for all control levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ena      = r_sync2[NUM_VOICES-1:0];
    assign w_oct_up   = r_sync2[NUM_VOICES];
    assign w_oct_down = r_sync2[NUM_VOICES+1];
    assign w_trem_ena = r_sync2[NUM_VOICES+2];
    assign w_led_ena  = r_sync2[NUM_VOICES+3];
    assign w_oct_mode = oct_mode(w_oct_up, w_oct_down);

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        tone_voice #(
            .DIV_W(DIV_W)
        ) u_voice (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_div     (i_voice_div[g*DIV_W +: DIV_W]),
            .i_ena     (w_ena[g]),
            .i_oct_mode(w_oct_mode),
            .o_square  (w_square[g])
        );
    end

    // Free-running LFO; keeps counting whether or not tremolo is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfo <= '0;
        else        r_lfo <= r_lfo + TREM_DIV_W'(1);
    end

    assign w_gated = (w_trem_ena && !r_lfo[TREM_DIV_W-1]) ? '0 : w_square;

    // Popcount of gated voices and sigma-delta accumulate.
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + ACC_W'(w_gated[i]);
        end
        w_acc_next = r_acc + w_sum;
        w_over     = (w_acc_next >= ACC_W'(NUM_VOICES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_out_full <= 1'b0;
            r_led_out  <= '0;
        end else begin
            r_acc      <= w_over ? (w_acc_next - ACC_W'(NUM_VOICES)) : w_acc_next;
            r_out_full <= w_over;
            r_led_out  <= w_square & {NUM_VOICES{w_led_ena}};
        end
    end

    assign o_out_full = r_out_full;
    assign o_led_out  = r_led_out;

endmodule

// File: tb/tb_multivoice_tone_gen.sv
// Directed bench for multivoice_tone_gen (2 voices, 8-bit dividers, 16-cycle LFO).
module tb_multivoice_tone_gen;

    localparam int unsigned NV = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NV*DW-1:0] i_voice_div;
    logic [NV-1:0] i_voice_ena;
    logic          i_octave_uena;
    logic          i_octave_dena;
    logic          i_tremolo_ena;
    logic          i_led_ena;
    logic          o_out_full;
    logic [NV-1:0] o_led_out;

    int n_vec = 0;
    int n_err = 0;

    multivoice_tone_gen #(
        .NUM_VOICES(NV),
        .DIV_W     (DW),
        .TREM_DIV_W(TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_voice_div  (i_voice_div),
        .i_voice_ena  (i_voice_ena),
        .i_octave_uena(i_octave_uena),
        .i_octave_dena(i_octave_dena),
        .i_tremolo_ena(i_tremolo_ena),
        .i_led_ena    (i_led_ena),
        .o_out_full   (o_out_full),
        .o_led_out    (o_led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until led_out[idx] next changes (capped at 64).
    task automatic wait_toggle(input int idx, output int n);
        logic prev;
        prev = o_led_out[idx];
        n = 0;
        do begin
            step();
            n++;
        end while (o_led_out[idx] === prev && n < 64);
    endtask

    task automatic skip_toggles(input int idx, input int k);
        int d;
        repeat (k) wait_toggle(idx, d);
    endtask

    task automatic settle(input int k);
        repeat (k) step();
    endtask

    initial begin
        int n, ones, viol, hits, zr, zmax, led_ones;

        rst_n         = 1'b1;
        i_voice_div   = '0;
        i_voice_ena   = '0;
        i_octave_uena = 1'b0;
        i_octave_dena = 1'b0;
        i_tremolo_ena = 1'b0;
        i_led_ena     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_full", int'(o_out_full), 0);
        chk("rst_led_out", int'(o_led_out), 0);
        settle(3);
        chk("rst_out_full_clk", int'(o_out_full), 0);
        chk("rst_led_out_clk", int'(o_led_out), 0);

        // Voice 0 at div=4, no octave: half-period 4.
        @(negedge clk);
        rst_n       = 1'b1;
        i_voice_div = {8'd0, 8'd4};
        i_voice_ena = 2'b01;
        i_led_ena   = 1'b1;
        skip_toggles(0, 2);
        wait_toggle(0, n);
        chk("half_base", n, 4);

        // One full period from a rising edge: 4 high cycles at sum=1 give 2 ones.
        n = 0;
        while (o_led_out[0] !== 1'b1 && n < 2) begin
            skip_toggles(0, 1);
            n++;
        end
        ones = 0;
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_out_full) ones++;
            if (o_out_full && !o_led_out[0]) viol++;
            step();
        end
        chk("density_ones", ones, 2);
        chk("density_low_phase", viol, 0);

        // Octave variants; two toggles skipped so the new mode has reloaded.
        i_octave_uena = 1'b1;
        skip_toggles(0, 2);
        wait_toggle(0, n);
        chk("half_oct_up", n, 2);
        i_octave_uena = 1'b0;
        i_octave_dena = 1'b1;
        skip_toggles(0, 2);
        wait_toggle(0, n);
        chk("half_oct_down", n, 8);
        i_octave_uena = 1'b1;
        skip_toggles(0, 2);
        wait_toggle(0, n);
        chk("half_oct_both", n, 4);
        i_octave_dena = 1'b0;
        i_voice_div   = {8'd0, 8'd1};
        skip_toggles(0, 3);
        wait_toggle(0, n);
        chk("half_div1_up_clamp", n, 1);
        i_octave_uena = 1'b0;

        // Both voices div=3 started together: full output while both high.
        i_voice_ena = 2'b00;
        settle(6);
        i_voice_div = {8'd3, 8'd3};
        i_voice_ena = 2'b11;
        n = 0;
        while (o_led_out !== 2'b11 && n < 16) begin
            step();
            n++;
        end
        chk("both_high_seen", int'(o_led_out === 2'b11), 1);
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_out_full) ones++;
            step();
        end
        chk("both_high_full", ones, 3);

        // Divider change mid-half-period only lands on the next reload.
        wait_toggle(0, n);
        i_voice_div = {8'd3, 8'd5};
        wait_toggle(0, n);
        chk("div_change_current", n, 3);
        wait_toggle(0, n);
        chk("div_change_next", n, 5);

        // div=0 keeps voice silent.
        i_voice_div = {8'd0, 8'd0};
        i_voice_ena = 2'b01;
        settle(12);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_led_out != '0 || o_out_full) hits++;
            step();
        end
        chk("silent_div0", hits, 0);

        // Disabled voices are silent even with a divider.
        i_voice_div = {8'd4, 8'd4};
        i_voice_ena = 2'b00;
        settle(6);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_led_out != '0 || o_out_full) hits++;
            step();
        end
        chk("silent_disabled", hits, 0);

        // LED mirror off: LEDs dark, audio still 8 high cycles per 16 -> 4 ones.
        i_voice_ena = 2'b01;
        i_led_ena   = 1'b0;
        settle(10);
        hits = 0;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (o_led_out != '0) hits++;
            if (o_out_full) ones++;
            step();
        end
        chk("led_off_dark", hits, 0);
        chk("led_off_audio", ones, 4);

        // Tremolo, div=1: audio passes only 8 of every 16 cycles; LEDs unaffected.
        i_led_ena     = 1'b1;
        i_voice_div   = {8'd0, 8'd1};
        i_tremolo_ena = 1'b1;
        settle(10);
        ones = 0;
        led_ones = 0;
        zr = 0;
        zmax = 0;
        for (int i = 0; i < 32; i++) begin
            if (o_led_out[0]) led_ones++;
            if (o_out_full) begin
                ones++;
                zr = 0;
            end else begin
                zr++;
                if (zr > zmax) zmax = zr;
            end
            step();
        end
        chk("trem_ones", ones, 4);
        chk("trem_led_ones", led_ones, 16);
        chk("trem_gap", int'(zmax >= 8), 1);

        // Async reset mid-tone, then restart at div=4.
        i_tremolo_ena = 1'b0;
        i_voice_div   = {8'd0, 8'd4};
        settle(10);
        n = 0;
        while (o_led_out[0] !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_led_out", int'(o_led_out), 0);
        chk("midrst_out_full", int'(o_out_full), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // 2 sync edges, reload/first rise on edge 3, LED register on edge 4.
        n = 0;
        do begin
            step();
            n++;
        end while (o_led_out[0] !== 1'b1 && n < 32);
        chk("restart_first_rise", n, 4);
        wait_toggle(0, n);
        chk("restart_first_toggle", n, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
